bgarb: RTL and testbench

BGARB -- requirements
Module: bgarb

---
 rtl/bgarb.sv | 188 ++++++++++++++++++
 tb/tb_bgarb.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bgarb.sv
// bgarb - bus grant arbiter for one NPR line and four BR levels (BR7..BR4).
//
// Picks one request, deglitches it for DEGLITCH cycles, then drives exactly
// one active-low grant until the bus master answers with SACK, the request
// goes away, or GRANT_TIMEOUT cycles pass with no answer.
//
// Parameters
//   DEGLITCH       cycles a request must hold in SETTLE before it is granted (1..15)
//   GRANT_TIMEOUT  GRANT cycles without SACK before the grant is withdrawn (1..255)
//
// Ports
//   CLOCK          rising-edge clock
//   RESET          asynchronous, active-high reset
//   br_in_h[3:0]   bus requests BR7..BR4 (bit i = level i+4)
//   npr_in_h       non-processor request (always outranks BR)
//   cpu_pri[2:0]   current processor priority
//   cpu_idle_h     processor at an instruction boundary (gates BR only)
//   sack_in_h      selection acknowledge from the granted device
//   bbsy_in_h      bus busy
//   init_in_h      bus INIT, synchronous clear
//   bg_out_l[3:0]  bus grants BG7..BG4, active low
//   npg_out_l      NPR grant, active low
//   timeout_out_h  one-cycle pulse when a grant is withdrawn for lack of SACK
//   state_out[1:0] current FSM state
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no target; waiting for a candidate request
// SETTLE   | target latched; counting consecutive cycles it stays valid
// GRANT    | one grant driven low; waiting for SACK, request drop or timeout
// WAITBUS  | grants high; waiting for SACK and BBSY to both clear

module bgarb #(
    parameter int DEGLITCH      = 4,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] br_in_h,
    input  logic       npr_in_h,
    input  logic [2:0] cpu_pri,
    input  logic       cpu_idle_h,
    input  logic       sack_in_h,
    input  logic       bbsy_in_h,
    input  logic       init_in_h,
    output logic [3:0] bg_out_l,
    output logic       npg_out_l,
    output logic       timeout_out_h,
    output logic [1:0] state_out
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_GRANT   = 2'd2;
    localparam logic [1:0] ST_WAITBUS = 2'd3;

    // Target encoding: 0..3 = BR4..BR7, 4 = NPR. Numeric order equals priority,
    // so "higher-priority candidate" is a plain magnitude compare.
    localparam logic [2:0] TGT_NPR = 3'd4;

    localparam logic [3:0] SETTLE_LAST = 4'(DEGLITCH - 1);
    localparam logic [7:0] TIMEOUT_VAL = 8'(GRANT_TIMEOUT);

    logic [1:0] state;
    logic [2:0] target;
    logic [3:0] settle_cnt;
    logic [7:0] grant_timer;

    logic [3:0] br_ok;
    logic       cand_valid;
    logic [2:0] cand_code;
    logic       target_ok;
    logic       target_held;
    logic [7:0] timer_inc;

    // A BR level is eligible only above the processor priority and only while
    // the processor sits at an instruction boundary.
    always_comb begin
        br_ok = '0;
        for (int i = 0; i < 4; i++) begin
            br_ok[i] = br_in_h[i] & cpu_idle_h & (cpu_pri < 3'(i + 4));
        end
    end

    always_comb begin
        cand_valid = npr_in_h | (|br_ok);
        cand_code  = TGT_NPR;
        if (!npr_in_h) begin
            cand_code = 3'd0;
            // ascending scan: the highest eligible level is written last
            for (int i = 0; i < 4; i++) begin
                if (br_ok[i]) begin
                    cand_code = 3'(i);
                end
            end
        end
    end

    // SETTLE needs the full qualification; once granted, only the raw request
    // line matters so processor priority/idle changes cannot revoke a grant.
    assign target_ok   = target[2] ? npr_in_h : br_ok[target[1:0]];
    assign target_held = target[2] ? npr_in_h : br_in_h[target[1:0]];

    // saturating increment: the timer never wraps
    assign timer_inc = (grant_timer == 8'hFF) ? grant_timer : grant_timer + 8'd1;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state         <= ST_IDLE;
            target        <= 3'd0;
            settle_cnt    <= 4'd0;
            grant_timer   <= 8'd0;
            bg_out_l      <= 4'b1111;
            npg_out_l     <= 1'b1;
            timeout_out_h <= 1'b0;
        end else begin
            timeout_out_h <= 1'b0;
            if (init_in_h) begin
                state       <= ST_IDLE;
                target      <= 3'd0;
                settle_cnt  <= 4'd0;
                grant_timer <= 8'd0;
                bg_out_l    <= 4'b1111;
                npg_out_l   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cand_valid) begin
                            target     <= cand_code;
                            settle_cnt <= 4'd0;
                            state      <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (!target_ok) begin
                            settle_cnt <= 4'd0;
                            state      <= ST_IDLE;
                        end else if (cand_valid && (cand_code > target)) begin
                            target     <= cand_code;
                            settle_cnt <= 4'd0;
                        end else if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt  <= 4'd0;
                            grant_timer <= 8'd0;
                            state       <= ST_GRANT;
                            if (target[2]) begin
                                npg_out_l <= 1'b0;
                            end else begin
                                bg_out_l <= ~(4'b0001 << target[1:0]);
                            end
                        end else begin
                            settle_cnt <= settle_cnt + 4'd1;
                        end
                    end
                    ST_GRANT: begin
                        if (sack_in_h) begin
                            bg_out_l  <= 4'b1111;
                            npg_out_l <= 1'b1;
                            state     <= ST_WAITBUS;
                        end else if (!target_held) begin
                            bg_out_l  <= 4'b1111;
                            npg_out_l <= 1'b1;
                            state     <= ST_IDLE;
                        end else if (timer_inc == TIMEOUT_VAL) begin
                            bg_out_l      <= 4'b1111;
                            npg_out_l     <= 1'b1;
                            timeout_out_h <= 1'b1;
                            grant_timer   <= 8'd0;
                            state         <= ST_IDLE;
                        end else begin
                            grant_timer <= timer_inc;
                        end
                    end
                    ST_WAITBUS: begin
                        if (!sack_in_h && !bbsy_in_h) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_bgarb.sv
module tb_bgarb;

    localparam int DEGLITCH      = 4;
    localparam int GRANT_TIMEOUT = 8;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] br_in_h = 4'b0;
    logic       npr_in_h = 1'b0;
    logic [2:0] cpu_pri = 3'd0;
    logic       cpu_idle_h = 1'b1;
    logic       sack_in_h = 1'b0;
    logic       bbsy_in_h = 1'b0;
    logic       init_in_h = 1'b0;
    logic [3:0] bg_out_l;
    logic       npg_out_l;
    logic       timeout_out_h;
    logic [1:0] state_out;

    bgarb #(.DEGLITCH(DEGLITCH), .GRANT_TIMEOUT(GRANT_TIMEOUT)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .br_in_h(br_in_h),
        .npr_in_h(npr_in_h),
        .cpu_pri(cpu_pri),
        .cpu_idle_h(cpu_idle_h),
        .sack_in_h(sack_in_h),
        .bbsy_in_h(bbsy_in_h),
        .init_in_h(init_in_h),
        .bg_out_l(bg_out_l),
        .npg_out_l(npg_out_l),
        .timeout_out_h(timeout_out_h),
        .state_out(state_out)
    );

    initial forever #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [3:0] bg;
        logic       npg;
        logic       to;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model. Requesters are numbered by bus level: 4..7 for BR,
    // 8 for NPR, -1 for none; larger number = higher priority.
    int m_mode = 0;   // 0 idle, 1 settle, 2 grant, 3 waitbus
    int m_tgt  = -1;
    int m_held = 0;   // consecutive qualified settle cycles
    int m_gcyc = 0;   // grant cycles elapsed
    bit m_to   = 1'b0;

    function automatic bit br_line(input int lvl);
        return |(br_in_h & (4'b0001 << (lvl - 4)));
    endfunction

    function automatic bit req_qualifies(input int t);
        if (t == 8) return npr_in_h;
        return br_line(t) && cpu_idle_h && (t > int'(cpu_pri));
    endfunction

    function automatic bit req_present(input int t);
        if (t == 8) return npr_in_h;
        return br_line(t);
    endfunction

    function automatic int top_cand();
        if (npr_in_h) return 8;
        for (int lvl = 7; lvl >= 4; lvl--) begin
            if (req_qualifies(lvl)) return lvl;
        end
        return -1;
    endfunction

    task automatic model_step();
        int   c;
        exp_t e;
        m_to = 1'b0;
        if (RESET || init_in_h) begin
            m_mode = 0; m_tgt = -1; m_held = 0; m_gcyc = 0;
        end else begin
            case (m_mode)
                0: begin
                    c = top_cand();
                    if (c >= 0) begin m_tgt = c; m_held = 0; m_mode = 1; end
                end
                1: begin
                    if (!req_qualifies(m_tgt)) begin
                        m_mode = 0;
                    end else begin
                        c = top_cand();
                        if (c > m_tgt) begin
                            m_tgt = c; m_held = 0;
                        end else begin
                            m_held++;
                            if (m_held == DEGLITCH) begin m_mode = 2; m_gcyc = 0; end
                        end
                    end
                end
                2: begin
                    if (sack_in_h) m_mode = 3;
                    else if (!req_present(m_tgt)) m_mode = 0;
                    else begin
                        m_gcyc++;
                        if (m_gcyc == GRANT_TIMEOUT) begin m_mode = 0; m_to = 1'b1; end
                    end
                end
                default: begin
                    if (!sack_in_h && !bbsy_in_h) m_mode = 0;
                end
            endcase
        end
        e.bg  = 4'b1111;
        e.npg = 1'b1;
        if (m_mode == 2 && m_tgt == 8) e.npg = 1'b0;
        if (m_mode == 2 && m_tgt >= 4 && m_tgt <= 7) e.bg = ~(4'b0001 << (m_tgt - 4));
        e.to = m_to;
        e.st = 2'(m_mode);
        exp_q.push_back(e);
    endtask

    // inputs only ever change at the falling edge
    task automatic tick();
        @(posedge CLOCK);
        model_step();
        @(negedge CLOCK);
    endtask

    // monitor: every edge the DUT presents a new output word
    initial begin
        exp_t e;
        int   lows;
        forever begin
            @(posedge CLOCK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_bg", int'(bg_out_l), int'(e.bg));
                check("sb_npg", int'(npg_out_l), int'(e.npg));
                check("sb_timeout", int'(timeout_out_h), int'(e.to));
                check("sb_state", int'(state_out), int'(e.st));
                lows = 5 - $countones({bg_out_l, npg_out_l});
                check("sb_one_grant_max", int'(lows <= 1), 1);
            end
        end
    end

    task automatic idle_inputs();
        br_in_h = 4'b0; npr_in_h = 1'b0; cpu_pri = 3'd0; cpu_idle_h = 1'b1;
        sack_in_h = 1'b0; bbsy_in_h = 1'b0; init_in_h = 1'b0;
    endtask

    task automatic wait_grant(input string name, output int n);
        n = 0;
        while (bg_out_l == 4'b1111 && npg_out_l && n < 30) begin
            tick();
            n++;
        end
        check({name, "_grant_seen"}, int'(bg_out_l != 4'b1111 || !npg_out_l), 1);
    endtask

    initial begin
        #100000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        idle_inputs();
        #1 RESET = 1'b1;
        #1;
        check("rst_state", int'(state_out), 0);
        check("rst_bg", int'(bg_out_l), 4'hF);
        check("rst_npg", int'(npg_out_l), 1);
        check("rst_timeout", int'(timeout_out_h), 0);
        tick(); tick();
        RESET = 1'b0;
        tick();

        // single BR4 above priority 3, then SACK
        cpu_pri = 3'd3; br_in_h = 4'b0001;
        wait_grant("a", n);
        check("a_latency", n, DEGLITCH + 1);
        check("a_bg", int'(bg_out_l), 4'b1110);
        sack_in_h = 1'b1;
        tick();
        check("a_sack_bg", int'(bg_out_l), 4'hF);
        check("a_sack_state", int'(state_out), 3);
        sack_in_h = 1'b0; br_in_h = 4'b0;
        tick();
        check("a_back_idle", int'(state_out), 0);

        // NPR beats BR5 raised in the same cycle
        cpu_pri = 3'd3; br_in_h = 4'b0010; npr_in_h = 1'b1;
        wait_grant("b1", n);
        check("b1_latency", n, DEGLITCH + 1);
        check("b1_npg", int'(npg_out_l), 0);
        check("b1_bg", int'(bg_out_l), 4'hF);
        sack_in_h = 1'b1;
        tick();
        idle_inputs(); cpu_pri = 3'd3;
        tick(); tick();

        // BR7 appears while BR5 is settling: retarget
        br_in_h = 4'b0010;
        tick(); tick();
        check("b2_settling", int'(state_out), 1);
        br_in_h = 4'b1010;
        wait_grant("b2", n);
        check("b2_latency", n, DEGLITCH + 1);
        check("b2_bg", int'(bg_out_l), 4'b0111);
        // processor state changes must not revoke the issued BR grant
        cpu_idle_h = 1'b0; cpu_pri = 3'd7;
        tick();
        check("b2_hold_bg", int'(bg_out_l), 4'b0111);
        br_in_h = 4'b0000;
        tick();
        check("b2_release_bg", int'(bg_out_l), 4'hF);
        check("b2_release_state", int'(state_out), 0);
        idle_inputs();
        tick();

        // priority masking
        cpu_pri = 3'd6; br_in_h = 4'b0011;
        repeat (10) tick();
        check("c_masked_bg", int'(bg_out_l), 4'hF);
        check("c_masked_state", int'(state_out), 0);
        cpu_pri = 3'd4;
        wait_grant("c", n);
        check("c_bg", int'(bg_out_l), 4'b1101);
        check("c_latency", n, DEGLITCH + 1);
        br_in_h = 4'b0;
        tick();

        // grant timeout
        idle_inputs();
        br_in_h = 4'b1000;
        wait_grant("d", n);
        m = 0;
        while (!timeout_out_h && m < 20) begin
            tick();
            m++;
        end
        check("d_timeout_cycles", m, GRANT_TIMEOUT);
        check("d_timeout_bg", int'(bg_out_l), 4'hF);
        check("d_timeout_state", int'(state_out), 0);
        tick();
        check("d_pulse_once", int'(timeout_out_h), 0);
        br_in_h = 4'b0;
        tick(); tick();

        // INIT during GRANT
        br_in_h = 4'b1000;
        wait_grant("e1", n);
        init_in_h = 1'b1;
        tick();
        check("e1_init_bg", int'(bg_out_l), 4'hF);
        check("e1_init_state", int'(state_out), 0);
        init_in_h = 1'b0; br_in_h = 4'b0;
        tick();

        // INIT during WAITBUS with BBSY held
        br_in_h = 4'b1000;
        wait_grant("e2", n);
        sack_in_h = 1'b1; bbsy_in_h = 1'b1;
        tick();
        sack_in_h = 1'b0;
        tick();
        check("e2_waitbus", int'(state_out), 3);
        init_in_h = 1'b1;
        tick();
        check("e2_init_state", int'(state_out), 0);
        check("e2_init_bg", int'(bg_out_l), 4'hF);
        idle_inputs();
        tick();

        // RESET during GRANT, then first grant after reset
        br_in_h = 4'b1000;
        wait_grant("e3", n);
        RESET = 1'b1;
        #1;
        check("e3_rst_bg", int'(bg_out_l), 4'hF);
        check("e3_rst_state", int'(state_out), 0);
        tick();
        RESET = 1'b0;
        wait_grant("e3_post", n);
        check("e3_post_latency", n, DEGLITCH + 1);
        br_in_h = 4'b0;
        tick();

        // RESET during WAITBUS with BBSY held
        br_in_h = 4'b0100;
        wait_grant("e4", n);
        sack_in_h = 1'b1; bbsy_in_h = 1'b1;
        tick();
        sack_in_h = 1'b0;
        RESET = 1'b1;
        #1;
        check("e4_rst_state", int'(state_out), 0);
        check("e4_rst_bg", int'(bg_out_l), 4'hF);
        tick();
        RESET = 1'b0;
        idle_inputs();
        tick();

        // randomized traffic against the model
        for (int s = 0; s < 300; s++) begin
            npr_in_h   = ($urandom_range(0, 5) == 0);
            br_in_h    = 4'($urandom);
            cpu_pri    = 3'($urandom);
            cpu_idle_h = ($urandom_range(0, 3) != 0);
            sack_in_h  = ($urandom_range(0, 4) == 0);
            bbsy_in_h  = ($urandom_range(0, 2) == 0);
            init_in_h  = ($urandom_range(0, 39) == 0);
            repeat ($urandom_range(1, 10)) tick();
        end

        idle_inputs();
        tick(); tick();
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
